// File: rtl/rwm_frame_reader_if.sv
// Memory-side request/data bus and downstream pixel stream of rwm_frame_reader.
// master = the frame reader, slave = the memory/consumer environment.
interface rwm_frame_reader_if;
  logic       mem_enable;
  logic       mem_rw;
  logic       mem_clear;
  logic [7:0] mem_data;
  logic       mem_valid;
  logic       mem_done;
  logic [7:0] pix_data;
  logic       pix_valid;
  logic       pix_ready;
  logic       pix_last_col;
  logic       pix_last;

  modport master (
    output mem_enable, mem_rw, mem_clear,
    input  mem_data, mem_valid, mem_done,
    output pix_data, pix_valid, pix_last_col, pix_last,
    input  pix_ready
  );

  modport slave (
    input  mem_enable, mem_rw, mem_clear,
    output mem_data, mem_valid, mem_done,
    input  pix_data, pix_valid, pix_last_col, pix_last,
    output pix_ready
  );
endinterface

// File: rtl/rwm_frame_reader.sv
// Reads one N*M-byte frame burst from the RWM, buffers it in a small FIFO and
// re-emits it as a ready/valid pixel stream. Optional watchdog: RWM_FRAME_READER_TIMEOUT_EN.
module rwm_frame_reader #(
  parameter int N           = 450,
  parameter int M           = 600,
  parameter int FIFO_DEPTH  = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_start,
  rwm_frame_reader_if.master bus,
  output logic               o_busy,
  output logic               o_frame_done,
  output logic               o_overflow,
  output logic               o_timeout_err
);

  localparam int PIX    = N * M;
  localparam int CNT_W  = (PIX > 1) ? $clog2(PIX) : 1;
  localparam int COL_W  = (M > 1) ? $clog2(M) : 1;
  localparam int ROW_W  = (N > 1) ? $clog2(N) : 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int FCNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(PIX - 1);
  localparam logic [COL_W-1:0]  LAST_COL = COL_W'(M - 1);
  localparam logic [ROW_W-1:0]  LAST_ROW = ROW_W'(N - 1);
  localparam logic [FCNT_W-1:0] FULL_CNT = FCNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_STREAM, S_DRAIN, S_DONE} state_t;

  state_t            r_state;
  logic [7:0]        r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [FCNT_W-1:0] r_count;
  logic [CNT_W-1:0]  r_in_cnt;
  logic [COL_W-1:0]  r_col;
  logic [ROW_W-1:0]  r_row;
  logic              r_mem_enable;
  logic              r_busy;
  logic              r_frame_done;
  logic              r_overflow;
  logic              r_timeout_err;

  logic w_capture;
  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;
  logic w_last_in;
  logic w_timeout;
  logic w_unused;

  // mem_data is only looked at in cycles qualified by mem_valid while a read is open.
  assign w_capture = bus.mem_valid && ((r_state == S_REQ) || (r_state == S_STREAM));
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == FULL_CNT);
  assign w_pop     = !w_empty && bus.pix_ready;
  assign w_push    = w_capture && (!w_full || w_pop);
  assign w_drop    = w_capture && w_full && !w_pop;
  assign w_last_in = w_capture && (r_in_cnt == LAST_IDX);
  assign w_unused  = bus.mem_done;

`ifdef RWM_FRAME_READER_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] r_wd_cnt;
  logic            w_waiting;

  assign w_waiting = ((r_state == S_REQ) || (r_state == S_STREAM)) && !bus.mem_valid;
  assign w_timeout = w_waiting && (r_wd_cnt == WD_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wd_cnt <= '0;
    end else if (w_waiting && !w_timeout) begin
      r_wd_cnt <= r_wd_cnt + WD_W'(1);
    end else begin
      r_wd_cnt <= '0;
    end
  end
`else
  logic w_unused_cfg;
  assign w_timeout    = 1'b0;
  assign w_unused_cfg = (TIMEOUT_CYC > 0);
`endif

  // NOTE: the FIFO storage has no reset; occupancy is tracked by r_count and
  // an entry is only ever read after it has been written.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= bus.mem_data;
    end
  end

  // NOTE: sequential state is written with <= so every register here sees
  // pre-edge values; later assignments in this block take priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_in_cnt      <= '0;
      r_col         <= '0;
      r_row         <= '0;
      r_mem_enable  <= 1'b0;
      r_busy        <= 1'b0;
      r_frame_done  <= 1'b0;
      r_overflow    <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;

      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop) begin
        r_count <= r_count + FCNT_W'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - FCNT_W'(1);
      end

      if (w_drop) r_overflow <= 1'b1;
      if (w_capture && !w_last_in) r_in_cnt <= r_in_cnt + CNT_W'(1);

      // Markers follow the popped-pixel count, not the source position.
      if (w_pop) begin
        if (r_col == LAST_COL) begin
          r_col <= '0;
          r_row <= (r_row == LAST_ROW) ? '0 : r_row + ROW_W'(1);
        end else begin
          r_col <= r_col + COL_W'(1);
        end
      end

      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state       <= S_REQ;
            r_mem_enable  <= 1'b1;
            r_busy        <= 1'b1;
            r_in_cnt      <= '0;
            r_col         <= '0;
            r_row         <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_overflow    <= 1'b0;
            r_timeout_err <= 1'b0;
          end
        end
        S_REQ: begin
          // Drop the request on the first byte so the RWM cannot re-arm a read.
          if (w_capture) begin
            r_mem_enable <= 1'b0;
            r_state      <= w_last_in ? S_DRAIN : S_STREAM;
          end
        end
        S_STREAM: begin
          if (w_last_in) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (w_empty) begin
            r_state      <= S_DONE;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase

      if (w_timeout) begin
        r_state       <= S_DONE;
        r_timeout_err <= 1'b1;
        r_mem_enable  <= 1'b0;
        r_busy        <= 1'b0;
        r_frame_done  <= 1'b1;
        r_wr_ptr      <= '0;
        r_rd_ptr      <= '0;
        r_count       <= '0;
      end
    end
  end

  assign bus.mem_enable   = r_mem_enable;
  assign bus.mem_rw       = 1'b0;
  assign bus.mem_clear    = 1'b0;
  assign bus.pix_valid    = !w_empty;
  assign bus.pix_data     = w_empty ? 8'h00 : r_fifo[r_rd_ptr];
  assign bus.pix_last_col = !w_empty && (r_col == LAST_COL);
  assign bus.pix_last     = !w_empty && (r_col == LAST_COL) && (r_row == LAST_ROW);

  assign o_busy        = r_busy;
  assign o_frame_done  = r_frame_done;
  assign o_overflow    = r_overflow;
  assign o_timeout_err = r_timeout_err;

endmodule

// File: tb/tb_rwm_frame_reader.sv
// Self-checking bench for rwm_frame_reader: queue-based frame model compared every
// cycle, directed frames from the test plan, then randomized frames.
module tb_rwm_frame_reader;

  localparam int N     = 2;
  localparam int M     = 3;
  localparam int DEPTH = 4;
  localparam int TOUT  = 8;
  localparam int PIX   = N * M;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic busy, frame_done, overflow, timeout_err;

  rwm_frame_reader_if bus ();

  rwm_frame_reader #(
    .N(N), .M(M), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TOUT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_start      (start),
    .bus          (bus),
    .o_busy       (busy),
    .o_frame_done (frame_done),
    .o_overflow   (overflow),
    .o_timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural frame model ----------------
  bit             m_active, m_fd, m_ovf, m_tout;
  int             m_got, m_popped, m_run;
  byte unsigned   m_q[$];
  bit             m_pop, m_full;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_active = 0; m_fd = 0; m_ovf = 0; m_tout = 0;
      m_got = 0; m_popped = 0; m_run = 0;
      m_q.delete();
    end else if (m_fd) begin
      m_fd = 0;
    end else if (!m_active) begin
      if (start) begin
        m_active = 1; m_got = 0; m_popped = 0; m_run = 0;
        m_ovf = 0; m_tout = 0;
        m_q.delete();
      end
    end else if (m_got == PIX && m_q.size() == 0) begin
      m_active = 0;
      m_fd     = 1;
    end else begin
      m_pop  = (m_q.size() != 0) && bus.pix_ready;
      m_full = (m_q.size() == DEPTH);
      if (m_pop) begin
        void'(m_q.pop_front());
        m_popped++;
      end
      if (m_got < PIX) begin
        if (bus.mem_valid) begin
          if (!m_full || m_pop) m_q.push_back(bus.mem_data);
          else m_ovf = 1;
          m_got++;
          m_run = 0;
        end
`ifdef RWM_FRAME_READER_TIMEOUT_EN
        else begin
          m_run++;
          if (m_run == TOUT) begin
            m_tout = 1; m_active = 0; m_fd = 1;
            m_q.delete();
          end
        end
`endif
      end
    end
  end

  // ---------------- per-cycle compare + logging ----------------
  int           fd_cnt = 0;
  int           en_cnt = 0;
  byte unsigned log_d[$];
  bit           log_lc[$];
  bit           log_l[$];
  bit           e_valid;
  int           e_col, e_row;

  always @(negedge clk) begin
    check("mem_rw", 32'(bus.mem_rw), 0);
    check("mem_clear", 32'(bus.mem_clear), 0);
    if (!rst_n) begin
      check("rst_mem_enable", 32'(bus.mem_enable), 0);
      check("rst_pix_valid", 32'(bus.pix_valid), 0);
      check("rst_pix_data", 32'(bus.pix_data), 0);
      check("rst_pix_last_col", 32'(bus.pix_last_col), 0);
      check("rst_pix_last", 32'(bus.pix_last), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_frame_done", 32'(frame_done), 0);
      check("rst_overflow", 32'(overflow), 0);
      check("rst_timeout_err", 32'(timeout_err), 0);
    end else begin
      e_valid = (m_q.size() != 0);
      e_col   = m_popped % M;
      e_row   = (m_popped / M) % N;
      check("pix_valid", 32'(bus.pix_valid), 32'(e_valid));
      if (e_valid) check("pix_data", 32'(bus.pix_data), 32'(m_q[0]));
      check("pix_last_col", 32'(bus.pix_last_col), 32'(e_valid && e_col == M - 1));
      check("pix_last", 32'(bus.pix_last), 32'(e_valid && e_col == M - 1 && e_row == N - 1));
      check("mem_enable", 32'(bus.mem_enable), 32'(m_active && m_got == 0));
      check("busy", 32'(busy), 32'(m_active));
      check("frame_done", 32'(frame_done), 32'(m_fd));
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("timeout_err", 32'(timeout_err), 32'(m_tout));
    end
    if (frame_done) fd_cnt++;
    if (bus.mem_enable) en_cnt++;
    if (bus.pix_valid && bus.pix_ready) begin
      log_d.push_back(bus.pix_data);
      log_lc.push_back(bus.pix_last_col);
      log_l.push_back(bus.pix_last);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One frame: start pulse, lat idle cycles, then PIX bytes. pix_ready is low
  // until `hold` bytes have been presented (or random). abort >= 0 resets mid-burst.
  task automatic run_frame(input bit [7:0] base, input bit rnd_data, input int lat,
                           input int hold, input bit rnd_ready, input bit rnd_gap,
                           input bit mid_start, input int abort);
    int  k, n;
    bit  aborted, released;
    k = 0; aborted = 0; released = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("mem_enable_after_start", 32'(bus.mem_enable), 1);
    repeat (lat) begin
      bus.mem_valid = 1'b0;
      bus.mem_data  = 'x;
      bus.pix_ready = rnd_ready ? ($urandom_range(0, 2) != 0) : (hold == 0);
      tick();
    end
    while (k < PIX) begin
      start = 1'b0;
      if (abort >= 0) begin
        if (k == abort && !aborted) begin
          rst_n   = 1'b0;
          aborted = 1;
          #1;
          check("async_rst_busy", 32'(busy), 0);
          check("async_rst_mem_enable", 32'(bus.mem_enable), 0);
          check("async_rst_pix_valid", 32'(bus.pix_valid), 0);
        end else if (aborted && !released && k >= abort + 2) begin
          rst_n    = 1'b1;
          released = 1;
        end
      end
      bus.pix_ready = rnd_ready ? ($urandom_range(0, 2) != 0) : (k >= hold);
      if (rnd_gap && $urandom_range(0, 3) == 0) begin
        bus.mem_valid = 1'b0;
        bus.mem_data  = 'x;
      end else begin
        bus.mem_valid = 1'b1;
        bus.mem_data  = rnd_data ? 8'($urandom) : 8'(base + k);
        if (mid_start && k == 2) start = 1'b1;
        k++;
      end
      tick();
    end
    start         = 1'b0;
    bus.mem_valid = 1'b0;
    bus.mem_data  = 'x;
    if (aborted && !released) rst_n = 1'b1;
    if (!aborted) begin
      n = fd_cnt;
      k = 0;
      while (fd_cnt == n && k < 100) begin
        bus.pix_ready = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
        tick();
        k++;
      end
      check("frame_done_within_bound", 32'(fd_cnt != n), 1);
    end
    bus.pix_ready = 1'b1;
    repeat (2) tick();
  endtask

  // Compare the pixels logged since index b against an expected byte list.
  task automatic expect_frame(input int b, input int f, input byte unsigned exp_q[$],
                              input bit exp_ovf);
    int got_last;
    got_last = 0;
    check("frame_pixel_count", 32'(log_d.size() - b), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && b + i < log_d.size(); i++) begin
      check("frame_pixel_data", 32'(log_d[b + i]), 32'(exp_q[i]));
      check("frame_pixel_last_col", 32'(log_lc[b + i]), 32'(i % M == M - 1));
      got_last += int'(log_l[b + i]);
    end
    check("frame_last_count", 32'(got_last), 32'(exp_q.size() == PIX));
    check("frame_done_pulses", 32'(fd_cnt - f), 1);
    check("frame_overflow", 32'(overflow), 32'(exp_ovf));
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit: simulation did not end by itself");
    $fatal(1);
  end

  initial begin
    byte unsigned eq[$];
    int b, f, e, n;
    rst_n         = 1'b0;
    start         = 1'b0;
    bus.mem_valid = 1'b0;
    bus.mem_data  = 'x;
    bus.mem_done  = 1'b0;
    bus.pix_ready = 1'b0;
    #2;
    check("reset_busy", 32'(busy), 0);
    check("reset_mem_enable", 32'(bus.mem_enable), 0);
    check("reset_pix_valid", 32'(bus.pix_valid), 0);
    check("reset_pix_data", 32'(bus.pix_data), 0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();

    // Basic frame 0x10..0x15 with pix_ready high.
    b = log_d.size(); f = fd_cnt;
    run_frame(8'h10, 0, 1, 0, 0, 0, 0, -1);
    eq = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
    expect_frame(b, f, eq, 0);

    // Backpressure for the first 4 captures: fits in the FIFO.
    b = log_d.size(); f = fd_cnt;
    run_frame(8'h20, 0, 1, 4, 0, 0, 0, -1);
    eq = '{8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25};
    expect_frame(b, f, eq, 0);

    // Backpressure for 5 captures: byte 0x34 is dropped.
    b = log_d.size(); f = fd_cnt;
    run_frame(8'h30, 0, 1, 5, 0, 0, 0, -1);
    eq = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h35};
    expect_frame(b, f, eq, 1);

    // Handshake: mem_enable spans start+1 .. first valid; mid-stream start ignored.
    b = log_d.size(); f = fd_cnt; e = en_cnt;
    run_frame(8'h40, 0, 2, 0, 0, 0, 1, -1);
    check("mem_enable_cycles", 32'(en_cnt - e), 3);
    eq = '{8'h40, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45};
    expect_frame(b, f, eq, 0);

    // Reset after 3 bytes, burst finishes unobserved, then a clean frame.
    f = fd_cnt;
    run_frame(8'h60, 0, 1, 0, 0, 0, 0, 3);
    check("aborted_frame_no_done", 32'(fd_cnt - f), 0);
    b = log_d.size(); f = fd_cnt;
    run_frame(8'h50, 0, 1, 0, 0, 0, 0, -1);
    eq = '{8'h50, 8'h51, 8'h52, 8'h53, 8'h54, 8'h55};
    expect_frame(b, f, eq, 0);

    // Randomized frames: random data, gaps, latency and backpressure.
    for (int r = 0; r < 12; r++) begin
      f = fd_cnt;
      run_frame(8'h00, 1, $urandom_range(1, 3), 0, 1, 1, (r % 3 == 0), -1);
      check("rnd_frame_done_pulses", 32'(fd_cnt - f), 1);
    end

`ifdef RWM_FRAME_READER_TIMEOUT_EN
    // Memory never answers: watchdog fires after TOUT request cycles.
    f = fd_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!timeout_err && n < 50) begin
      tick();
      n++;
    end
    check("timeout_cycles", 32'(n), TOUT);
    check("timeout_frame_done", 32'(frame_done), 1);
    repeat (3) tick();
    check("timeout_done_pulses", 32'(fd_cnt - f), 1);
    check("timeout_back_idle_busy", 32'(busy), 0);
    b = log_d.size(); f = fd_cnt;
    run_frame(8'h70, 0, 1, 0, 0, 0, 0, -1);
    eq = '{8'h70, 8'h71, 8'h72, 8'h73, 8'h74, 8'h75};
    expect_frame(b, f, eq, 0);
    check("timeout_cleared_by_start", 32'(timeout_err), 0);
`endif

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rwm_frame_reader.md
# rwm_frame_reader

Read-side client of the RWM frame memory. On a `start` pulse it issues a read request (`RWM_enable=1`, `rw=0`, `clear=0`) and captures the uninterruptible `N*M`-byte burst presented with `RWM_valid`. It buffers the bytes in a small FIFO and re-emits them on a ready/valid pixel stream with row/column markers. Downstream consumers can therefore stall without the frame memory having to pause.

## Interface
- `N`, 450, image height in rows
- `M`, 600, image width in pixels
- `FIFO_DEPTH`, 16, buffer depth in bytes; power of two, ≥2
- `TIMEOUT_CYC`, 1024, watchdog limit; used only with the macro
---
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `start`  in  1  one-cycle pulse requesting one frame read
- `mem_enable`  out  1  to RWM `RWM_enable`
- `mem_rw`  out  1  to RWM `rw`; constant 0
- `mem_clear`  out  1  to RWM `clear`; constant 0
- `mem_data`  in  8  from RWM `data_out`; may be Z outside valid cycles
- `mem_valid`  in  1  from RWM `RWM_valid`
- `mem_done`  in  1  from RWM `RWM_done`; informational only
- `pix_data`  out  8  output pixel
- `pix_valid`  out  1  output pixel valid
- `pix_ready`  in  1  downstream accept
- `pix_last_col`  out  1  pixel is column `M-1`; qualified by `pix_valid`
- `pix_last`  out  1  pixel is row `N-1`, column `M-1`
- `busy`  out  1  high from the cycle after `start` until `frame_done`
- `frame_done`  out  1  one-cycle pulse at end of frame
- `overflow`  out  1  sticky; a byte was dropped; cleared by the next accepted `start`
- `timeout_err`  out  1  sticky watchdog flag; cleared by the next accepted `start`

## Operation
- States: IDLE, REQ, STREAM, DRAIN, DONE.
- IDLE:
  - `start=1` → REQ.
  - Same edge clears `in_cnt`, row/col counters, FIFO pointers, `overflow` and `timeout_err`.
  - `start` is ignored in every other state.
- REQ:
  - `mem_enable=1`.
  - First `mem_valid=1` → STREAM; that byte is captured.
- STREAM:
  - `mem_enable=0`.
  - `mem_enable` must be low before the RWM returns to INACTIVE so that it does not restart a read.
  - Every `mem_valid=1` cycle captures `mem_data` and increments `in_cnt`.
  - Capture with `in_cnt == N*M-1` → DRAIN.
- DRAIN: FIFO empty → DONE.
- DONE: `frame_done=1` for one cycle → IDLE.
- `mem_data` is sampled only when `mem_valid=1`; Z/X values at other times must never reach the FIFO.
- FIFO write:
  - Occurs on `mem_valid`.
  - If full and no pop this cycle, the byte is dropped, `overflow` is set, and `in_cnt` still increments.
  - Full with a simultaneous pop: the write is accepted.
- FIFO read: pop when `pix_valid & pix_ready`; `pix_valid = !empty`.
- Output counters (`col` 0..M-1, `row` 0..N-1) advance on each pop; `col` wraps at `M-1` and `row` increments.
- After an overflow the markers reflect popped-pixel count, not source position. `pix_last` may then never assert; `frame_done` still fires via DRAIN.
- `mem_done` is not used for control; `in_cnt` is authoritative.
- Widths:
  - `in_cnt` and the pixel index are `$clog2(N*M)` bits.
  - FIFO count is `$clog2(FIFO_DEPTH)+1` bits.
  - Counters never exceed their terminal values.

## Timing
- Reset values: state IDLE; all outputs 0 (`mem_enable`, `pix_valid`, `pix_last_col`, `pix_last`, `busy`, `frame_done`, `overflow`, `timeout_err`); `pix_data` is 0.
- `start` at edge k → `mem_enable=1` and `busy=1` from cycle k+1.
- Byte captured at edge t → `pix_valid=1` with that byte from cycle t+1 (one-cycle latency, FIFO registered).
- With `pix_ready` held high, throughput is one pixel per cycle; the FIFO never holds more than one byte.
- `frame_done` is asserted the cycle after the FIFO goes empty with all `N*M` bytes received.
- `busy` falls in the same cycle as the `frame_done` pulse.
- `rst_n` low mid-frame:
  - All state clears immediately and `mem_enable` drops asynchronously.
  - Any partial frame is discarded and the memory burst completes unobserved.
  - The next `start` must wait for the memory's `mem_valid` to fall.

## Configuration
- `RWM_FRAME_READER_TIMEOUT_EN` defined:
  - A watchdog counts consecutive cycles in REQ or STREAM with `mem_valid=0`.
  - Reaching `TIMEOUT_CYC` sets `timeout_err`, deasserts `mem_enable`, flushes the FIFO, pulses `frame_done`, and returns to IDLE.
- Undefined: no watchdog; the block waits indefinitely; `timeout_err` is tied to 0.

## Test plan
- Basic frame (`N=2`, `M=3`, `pix_ready=1`): memory model streams 0x10..0x15 → output is 0x10..0x15 each one cycle after capture; `pix_last_col` on 0x12 and 0x15; `pix_last` on 0x15; one `frame_done` pulse; `overflow=0`.
- Backpressure within depth (`FIFO_DEPTH=4`, `N=2`, `M=3`): `pix_ready=0` during the first 4 captures, then 1 → all 6 bytes in order; `overflow=0`.
- Overflow: same setup, `pix_ready=0` for 5 captures → 5th byte dropped, `overflow=1`, 5 pixels delivered, `frame_done` pulses, `pix_last` never asserts.
- Handshake: `mem_enable` is high from `start+1` through the first `mem_valid` and low thereafter; `start` pulsed mid-STREAM has no effect.
- Reset mid-stream after 3 bytes → all outputs 0 within the reset cycle; a new `start` then reads a full, clean frame.
- With `RWM_FRAME_READER_TIMEOUT_EN` and `TIMEOUT_CYC=8`: memory never responds → `timeout_err=1` after 8 REQ cycles, `frame_done` pulses, return to IDLE.
